// File: rtl/mvb_discard_stats.sv
// mvb_discard_stats
// -----------------------------------------------------------------------------
// Per-channel frame statistics placed directly after the RX MAC Lite discard
// MVB stream. Each MVB item carries one discard flag. The block counts valid
// items (frames seen) and items with the flag set (frames discarded). It also
// provides an atomic snapshot and an atomic clear for MI-facing status regs.
//
// Pipeline:
//   stage 1 : per-word popcounts of VLD and VLD&DATA are registered
//   stage 2 : counters accumulate the registered increments
//   A word accepted in cycle n is visible on CNT_* from cycle n+2.
//
// Optional feature (compile-time macro MVB_DISCARD_STATS_SAT_EN):
//   defined   : counters saturate at all-ones and hold until CNT_CLR
//   undefined : counters wrap modulo 2^CNT_WIDTH
//   In both builds OVERFLOW is a sticky flag, cleared by CNT_CLR or RESET.
//
// Parameters:
//   REGIONS   - MVB items per word (matches RX MAC Lite regions)
//   CNT_WIDTH - width of every counter and snapshot (minimum 8)
//
// Ports:
//   CLK            in   clock
//   RESET          in   asynchronous active-high reset
//   RX_MVB_DATA    in   per-item discard flag (1 = frame discarded)
//   RX_MVB_VLD     in   per-item valid
//   RX_MVB_SRC_RDY in   word valid
//   RX_MVB_DST_RDY out  constant 1, the block never stalls
//   CNT_CLR        in   single-cycle clear request
//   SNAP_REQ       in   single-cycle snapshot request
//   CNT_TOTAL      out  live count of valid items
//   CNT_DISC       out  live count of discarded items
//   SNAP_TOTAL     out  snapshot of CNT_TOTAL
//   SNAP_DISC      out  snapshot of CNT_DISC
//   SNAP_VLD       out  one-cycle pulse, snapshot registers were updated
//   OVERFLOW       out  sticky, a counter wrapped or saturated
// -----------------------------------------------------------------------------
module mvb_discard_stats #(
    parameter int unsigned REGIONS   = 4,
    parameter int unsigned CNT_WIDTH = 64
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic [REGIONS-1:0]   RX_MVB_DATA,
    input  logic [REGIONS-1:0]   RX_MVB_VLD,
    input  logic                 RX_MVB_SRC_RDY,
    output logic                 RX_MVB_DST_RDY,
    input  logic                 CNT_CLR,
    input  logic                 SNAP_REQ,
    output logic [CNT_WIDTH-1:0] CNT_TOTAL,
    output logic [CNT_WIDTH-1:0] CNT_DISC,
    output logic [CNT_WIDTH-1:0] SNAP_TOTAL,
    output logic [CNT_WIDTH-1:0] SNAP_DISC,
    output logic                 SNAP_VLD,
    output logic                 OVERFLOW
);

    // Wide enough to hold REGIONS itself (all items valid).
    localparam int unsigned INC_W = $clog2(REGIONS + 1);

    // -------------------------------------------------------------------------
    // Stage 1: per-word increments
    // -------------------------------------------------------------------------
    logic [INC_W-1:0] inc_tot_d, inc_tot_q;
    logic [INC_W-1:0] inc_dis_d, inc_dis_q;

    // VLD is qualified by SRC_RDY here, so an idle word feeds a zero increment.
    always_comb begin
        inc_tot_d = '0;
        inc_dis_d = '0;
        for (int i = 0; i < REGIONS; i++) begin
            if (RX_MVB_SRC_RDY && RX_MVB_VLD[i]) begin
                inc_tot_d = inc_tot_d + INC_W'(1);
                if (RX_MVB_DATA[i]) begin
                    inc_dis_d = inc_dis_d + INC_W'(1);
                end
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            inc_tot_q <= '0;
            inc_dis_q <= '0;
        end else begin
            inc_tot_q <= inc_tot_d;
            inc_dis_q <= inc_dis_d;
        end
    end

    // -------------------------------------------------------------------------
    // Stage 2: accumulation
    // -------------------------------------------------------------------------
    logic [CNT_WIDTH-1:0] cnt_tot_d, cnt_tot_q;
    logic [CNT_WIDTH-1:0] cnt_dis_d, cnt_dis_q;
    logic [CNT_WIDTH-1:0] base_tot, base_dis;
    logic [CNT_WIDTH-1:0] sum_tot, sum_dis;
    logic                 carry_tot, carry_dis;
    logic                 ovf_d, ovf_q;

    // A clear zeroes the base but still adds the pending stage-1 increment,
    // so a word that is in flight during the clear is not lost.
    always_comb begin
        base_tot = CNT_CLR ? '0 : cnt_tot_q;
        base_dis = CNT_CLR ? '0 : cnt_dis_q;

        // One extra bit on the adder exposes the carry-out.
        {carry_tot, sum_tot} = {1'b0, base_tot} + (CNT_WIDTH + 1)'(inc_tot_q);
        {carry_dis, sum_dis} = {1'b0, base_dis} + (CNT_WIDTH + 1)'(inc_dis_q);

`ifdef MVB_DISCARD_STATS_SAT_EN
        // Clamp to all-ones. Once saturated, every non-zero increment carries
        // again, so the counter holds until the next clear.
        cnt_tot_d = carry_tot ? '1 : sum_tot;
        cnt_dis_d = carry_dis ? '1 : sum_dis;
`else
        cnt_tot_d = sum_tot;
        cnt_dis_d = sum_dis;
`endif

        // Clear has priority over a coinciding carry-out. With a zero base,
        // a carry cannot happen in that cycle anyway.
        if (CNT_CLR) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q | carry_tot | carry_dis;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            cnt_tot_q <= '0;
            cnt_dis_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            cnt_tot_q <= cnt_tot_d;
            cnt_dis_q <= cnt_dis_d;
            ovf_q     <= ovf_d;
        end
    end

    // -------------------------------------------------------------------------
    // Snapshot
    // -------------------------------------------------------------------------
    logic [CNT_WIDTH-1:0] snap_tot_q, snap_dis_q;
    logic                 snap_vld_q;

    // The snapshot samples the counter registers as they are in the request
    // cycle: before the pending increment and before a coinciding clear.
    // Together with the clear path, snapshot + restarted count is exact.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            snap_tot_q <= '0;
            snap_dis_q <= '0;
            snap_vld_q <= 1'b0;
        end else begin
            snap_vld_q <= SNAP_REQ;
            if (SNAP_REQ) begin
                snap_tot_q <= cnt_tot_q;
                snap_dis_q <= cnt_dis_q;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign RX_MVB_DST_RDY = 1'b1;
    assign CNT_TOTAL      = cnt_tot_q;
    assign CNT_DISC       = cnt_dis_q;
    assign SNAP_TOTAL     = snap_tot_q;
    assign SNAP_DISC      = snap_dis_q;
    assign SNAP_VLD       = snap_vld_q;
    assign OVERFLOW       = ovf_q;

endmodule

// File: tb/tb_mvb_discard_stats.sv
// tb_mvb_discard_stats
// Directed scenarios plus a random phase for mvb_discard_stats. A second
// instance with 8-bit counters covers wrap/saturation. The reference model
// records per cycle what was accepted, cleared and requested. The expected
// counter value in cycle t is then a plain sum over the window of accepted
// words that the rules make visible in that cycle.
module tb_mvb_discard_stats;

    localparam int unsigned REGIONS = 4;
    localparam int unsigned CW      = 64;
    localparam int unsigned SW      = 8;
    localparam int          MAXC    = 12000;

    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    rx_data, rx_vld;
    logic          rx_src_rdy, cnt_clr, snap_req;
    logic          rx_dst_rdy;
    logic [CW-1:0] cnt_total, cnt_disc, snap_total, snap_disc;
    logic          snap_vld, overflow;

    logic [3:0]    s_data, s_vld;
    logic          s_src_rdy, s_clr, s_snap;
    logic          s_dst_rdy;
    logic [SW-1:0] s_cnt_total, s_cnt_disc, s_snap_total, s_snap_disc;
    logic          s_snap_vld, s_overflow;

    always #5 clk = ~clk;

    mvb_discard_stats #(.REGIONS(REGIONS), .CNT_WIDTH(CW)) dut (
        .CLK(clk), .RESET(rst),
        .RX_MVB_DATA(rx_data), .RX_MVB_VLD(rx_vld), .RX_MVB_SRC_RDY(rx_src_rdy),
        .RX_MVB_DST_RDY(rx_dst_rdy), .CNT_CLR(cnt_clr), .SNAP_REQ(snap_req),
        .CNT_TOTAL(cnt_total), .CNT_DISC(cnt_disc), .SNAP_TOTAL(snap_total),
        .SNAP_DISC(snap_disc), .SNAP_VLD(snap_vld), .OVERFLOW(overflow)
    );

    mvb_discard_stats #(.REGIONS(REGIONS), .CNT_WIDTH(SW)) dut8 (
        .CLK(clk), .RESET(rst),
        .RX_MVB_DATA(s_data), .RX_MVB_VLD(s_vld), .RX_MVB_SRC_RDY(s_src_rdy),
        .RX_MVB_DST_RDY(s_dst_rdy), .CNT_CLR(s_clr), .SNAP_REQ(s_snap),
        .CNT_TOTAL(s_cnt_total), .CNT_DISC(s_cnt_disc), .SNAP_TOTAL(s_snap_total),
        .SNAP_DISC(s_snap_disc), .SNAP_VLD(s_snap_vld), .OVERFLOW(s_overflow)
    );

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    // Model history, indexed by cycle number since the last reset release.
    int          cyc     = 0;
    int          floor_c = 0;
    int unsigned inc_tot [MAXC];
    int unsigned inc_dis [MAXC];
    bit          clr_at  [MAXC];
    bit          snap_at [MAXC];
    logic [63:0] last_snap_tot = '0;
    logic [63:0] last_snap_dis = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Frames visible in cycle t are those accepted in [lo, t-2]. lo is one
    // cycle before the most recent clear issued no later than t-1 (its pending
    // word survives), or the reset release point.
    function automatic void model_cnt(input int t, output longint unsigned tot,
                                      output longint unsigned dis);
        int lo;
        lo  = floor_c;
        tot = 0;
        dis = 0;
        for (int c = t - 1; c >= floor_c; c--) begin
            if (clr_at[c]) begin
                lo = (c - 1 > floor_c) ? c - 1 : floor_c;
                break;
            end
        end
        for (int n = lo; n <= t - 2; n++) begin
            tot += longint'(inc_tot[n]);
            dis += longint'(inc_dis[n]);
        end
    endfunction

    // Drive one cycle's inputs, then check all main-DUT outputs at the negedge.
    task automatic cyc_begin(input logic [3:0] vld, input logic [3:0] data,
                             input logic src, input logic clr, input logic snap);
        longint unsigned et, ed, st, sd;
        logic            esv;
        if (cyc >= MAXC) begin
            $display("FAIL model_capacity: observed cycle %0d required below %0d", cyc, MAXC);
            $fatal(1, "model history exhausted");
        end
        rx_vld     = vld;
        rx_data    = data;
        rx_src_rdy = src;
        cnt_clr    = clr;
        snap_req   = snap;
        inc_tot[cyc] = src ? 32'($countones(vld)) : 0;
        inc_dis[cyc] = src ? 32'($countones(vld & data)) : 0;
        clr_at[cyc]  = clr;
        snap_at[cyc] = snap;
        @(negedge clk);
        model_cnt(cyc, et, ed);
        chk("cnt_total", cnt_total, et);
        chk("cnt_disc", cnt_disc, ed);
        esv = 1'b0;
        if (cyc - 1 >= floor_c && snap_at[cyc-1]) begin
            model_cnt(cyc - 1, st, sd);
            last_snap_tot = st;
            last_snap_dis = sd;
            esv = 1'b1;
        end
        chk("snap_vld", 64'(snap_vld), 64'(esv));
        chk("snap_total", snap_total, last_snap_tot);
        chk("snap_disc", snap_disc, last_snap_dis);
        chk("overflow_main", 64'(overflow), 64'd0);
        chk("dst_rdy", 64'(rx_dst_rdy), 64'd1);
    endtask

    task automatic cyc_end();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drive(input logic [3:0] vld, input logic [3:0] data,
                         input logic src, input logic clr, input logic snap);
        cyc_begin(vld, data, src, clr, snap);
        cyc_end();
    endtask

    task automatic small_step(input logic [3:0] vld, input logic clr);
        s_vld     = vld;
        s_data    = 4'b0000;
        s_src_rdy = (vld != 4'b0000);
        s_clr     = clr;
        @(posedge clk);
        #1;
    endtask

    longint unsigned rnd_tot, rnd_dis, sum_tot, sum_dis;
    logic [3:0]      r_vld, r_data;
    logic            r_src, sc, so, prev_sc;
    int unsigned     r;

    initial begin
        rst = 1'b1;
        rx_vld = '0; rx_data = '0; rx_src_rdy = 1'b0; cnt_clr = 1'b0; snap_req = 1'b0;
        s_vld = '0; s_data = '0; s_src_rdy = 1'b0; s_clr = 1'b0; s_snap = 1'b0;

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_cnt_total", cnt_total, 64'd0);
        chk("rst_cnt_disc", cnt_disc, 64'd0);
        chk("rst_snap_vld", 64'(snap_vld), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        chk("rst_dst_rdy", 64'(rx_dst_rdy), 64'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
        floor_c = 0;

        // 10 full words with alternating discard flags -> 40/20.
        for (int i = 0; i < 10; i++) drive(4'b1111, 4'b0101, 1'b1, 1'b0, 1'b0);
        drive(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
        cyc_begin(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
        chk("t1_total", cnt_total, 64'd40);
        chk("t1_disc", cnt_disc, 64'd20);
        cyc_end();

        // Clear, then SRC_RDY=0 words interleaved with 3 real words -> 6/3.
        drive(4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive(4'b1111, 4'b1111, 1'b0, 1'b0, 1'b0);
            drive(4'b0011, 4'b0001, 1'b1, 1'b0, 1'b0);
        end
        drive(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
        cyc_begin(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
        chk("t2_total", cnt_total, 64'd6);
        chk("t2_disc", cnt_disc, 64'd3);
        cyc_end();

        // Build 100/30, then word in n, snapshot+clear in n+1.
        drive(4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) drive(4'b1111, 4'b0111, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 15; i++) drive(4'b1111, 4'b0000, 1'b1, 1'b0, 1'b0);
        drive(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
        cyc_begin(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
        chk("t3_pre_total", cnt_total, 64'd100);
        chk("t3_pre_disc", cnt_disc, 64'd30);
        cyc_end();
        drive(4'b1111, 4'b1111, 1'b1, 1'b0, 1'b0);
        drive(4'b0000, 4'b0000, 1'b0, 1'b1, 1'b1);
        cyc_begin(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
        chk("t3_snap_total", snap_total, 64'd100);
        chk("t3_snap_disc", snap_disc, 64'd30);
        chk("t3_snap_vld", 64'(snap_vld), 64'd1);
        chk("t3_cnt_total", cnt_total, 64'd4);
        chk("t3_cnt_disc", cnt_disc, 64'd4);
        cyc_end();

        // Back-to-back snapshot requests keep SNAP_VLD high.
        drive(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1);
        drive(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1);
        cyc_begin(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
        chk("b2b_snap_vld", 64'(snap_vld), 64'd1);
        cyc_end();

        // Build 50/5, leave a word pending, then reset asynchronously.
        drive(4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) drive(4'b1111, 4'b0001, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) drive(4'b1111, 4'b0000, 1'b1, 1'b0, 1'b0);
        drive(4'b0011, 4'b0000, 1'b1, 1'b0, 1'b0);
        drive(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
        cyc_begin(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
        chk("t5_pre_total", cnt_total, 64'd50);
        chk("t5_pre_disc", cnt_disc, 64'd5);
        cyc_end();
        drive(4'b1111, 4'b1111, 1'b1, 1'b0, 1'b1);
        rx_vld = '0; rx_data = '0; rx_src_rdy = 1'b0; snap_req = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        chk("arst_cnt_total", cnt_total, 64'd0);
        chk("arst_cnt_disc", cnt_disc, 64'd0);
        chk("arst_snap_total", snap_total, 64'd0);
        chk("arst_snap_disc", snap_disc, 64'd0);
        chk("arst_snap_vld", 64'(snap_vld), 64'd0);
        chk("arst_overflow", 64'(overflow), 64'd0);
        chk("arst_dst_rdy", 64'(rx_dst_rdy), 64'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc++;
        floor_c = cyc;
        last_snap_tot = '0;
        last_snap_dis = '0;
        drive(4'b0001, 4'b0001, 1'b1, 1'b0, 1'b0);
        drive(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
        cyc_begin(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
        chk("t5_post_total", cnt_total, 64'd1);
        chk("t5_post_disc", cnt_disc, 64'd1);
        cyc_end();

        // Random phase: every clear is paired with a snapshot. The snapshots
        // plus the final count must then add up to every accepted frame.
        drive(4'b0000, 4'b0000, 1'b0, 1'b1, 1'b1);
        rnd_tot = 0; rnd_dis = 0; sum_tot = 0; sum_dis = 0;
        prev_sc = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            r_src  = ($urandom_range(0, 3) != 0);
            r_vld  = 4'($urandom);
            r_data = 4'($urandom);
            r      = $urandom_range(0, 63);
            sc     = (r < 2);
            so     = (r >= 2 && r < 6);
            cyc_begin(r_vld, r_data, r_src, sc, sc | so);
            if (prev_sc) begin
                sum_tot += snap_total;
                sum_dis += snap_disc;
            end
            if (r_src) begin
                rnd_tot += longint'($countones(r_vld));
                rnd_dis += longint'($countones(r_vld & r_data));
            end
            cyc_end();
            prev_sc = sc;
        end
        cyc_begin(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
        if (prev_sc) begin
            sum_tot += snap_total;
            sum_dis += snap_disc;
        end
        cyc_end();
        cyc_begin(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
        chk("rnd_sum_total", sum_tot + cnt_total, rnd_tot);
        chk("rnd_sum_disc", sum_dis + cnt_disc, rnd_dis);
        cyc_end();

        // 8-bit instance: reach 254, then add 4 -> wrap to 2 or saturate at 255.
        for (int i = 0; i < 63; i++) small_step(4'b1111, 1'b0);
        small_step(4'b0011, 1'b0);
        repeat (2) small_step(4'b0000, 1'b0);
        @(negedge clk);
        chk("w8_pre_total", 64'(s_cnt_total), 64'd254);
        chk("w8_pre_ovf", 64'(s_overflow), 64'd0);
        @(posedge clk);
        #1;
        small_step(4'b1111, 1'b0);
        repeat (2) small_step(4'b0000, 1'b0);
        @(negedge clk);
`ifdef MVB_DISCARD_STATS_SAT_EN
        chk("w8_total", 64'(s_cnt_total), 64'd255);
`else
        chk("w8_total", 64'(s_cnt_total), 64'd2);
`endif
        chk("w8_disc", 64'(s_cnt_disc), 64'd0);
        chk("w8_ovf", 64'(s_overflow), 64'd1);
        @(posedge clk);
        #1;
        small_step(4'b0000, 1'b0);
        @(negedge clk);
        chk("w8_ovf_sticky", 64'(s_overflow), 64'd1);
        @(posedge clk);
        #1;
        small_step(4'b0000, 1'b1);
        s_clr = 1'b0;
        @(negedge clk);
        chk("w8_clr_total", 64'(s_cnt_total), 64'd0);
        chk("w8_clr_ovf", 64'(s_overflow), 64'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
